// File: rtl/alu_seq_loader_if.sv
// Switch/button inputs and LED/status outputs for the sequential ALU loader.
// The master side drives the operand, opcode and load level; the slave is the loader.
interface alu_seq_loader_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_dato;
    logic [NB_OP-1:0]   i_operation;
    logic               i_load;
    logic [NB_DATA-1:0] o_leds;
    logic [1:0]         o_state;
    logic               o_valid;
    logic               o_carry;
    logic               o_zero;
    logic               o_op_err;

    modport master (
        output i_dato, i_operation, i_load,
        input  o_leds, o_state, o_valid, o_carry, o_zero, o_op_err
    );

    modport slave (
        input  i_dato, i_operation, i_load,
        output o_leds, o_state, o_valid, o_carry, o_zero, o_op_err
    );
endinterface

// File: rtl/alu_seq_loader.sv
// Loads A, B and an opcode on successive button presses, then shows the registered ALU result.
// Result and flags update on the op-load edge; no backpressure, one event per press.
module alu_seq_loader #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic            clk,
    input  logic            i_reset,
    alu_seq_loader_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_LOAD_OP = 2'b10,
        S_SHOW    = 2'b11
    } state_t;

    localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

    localparam logic [32:0] WIDTH_EXT = 33'(NB_DATA);

    state_t             state_q;
    state_t             state_d;
    logic               load_d;
    logic               load_ev;

    logic [NB_DATA-1:0] reg_a;
    logic [NB_DATA-1:0] reg_b;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] leds_q;
    logic               carry_q;
    logic               zero_q;
    logic               err_q;
    logic               valid_q;

    logic [NB_OP-1:0]   op_sel;
    logic [NB_DATA:0]   sum;
    logic               big_shift;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_cy;
    logic               alu_err;

    // Rising edge of the level button relative to its previous sample.
    assign load_ev = bus.i_load & ~load_d;

    // The ALU follows the live opcode switches while waiting for the op load,
    // and the captured opcode otherwise; its output is only sampled at capture.
    assign op_sel    = (state_q == S_LOAD_OP) ? bus.i_operation : op_q;
    assign sum       = {1'b0, reg_a} + {1'b0, reg_b};
    assign big_shift = (33'(reg_b) >= WIDTH_EXT);

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        alu_err = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_res = sum[NB_DATA-1:0];
                alu_cy  = sum[NB_DATA];
            end
            OP_SUB: begin
                alu_res = reg_a - reg_b;
                alu_cy  = (reg_a < reg_b);
            end
            OP_AND: alu_res = reg_a & reg_b;
            OP_OR:  alu_res = reg_a | reg_b;
            OP_XOR: alu_res = reg_a ^ reg_b;
            OP_NOR: alu_res = ~(reg_a | reg_b);
            OP_SRA: begin
                if (big_shift) begin
                    alu_res = {NB_DATA{reg_a[NB_DATA-1]}};
                end else begin
                    alu_res = $unsigned($signed(reg_a) >>> reg_b);
                end
            end
            OP_SRL: begin
                if (big_shift) begin
                    alu_res = '0;
                end else begin
                    alu_res = reg_a >> reg_b;
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (load_ev) begin
            case (state_q)
                S_LOAD_A:  state_d = S_LOAD_B;
                S_LOAD_B:  state_d = S_LOAD_OP;
                S_LOAD_OP: state_d = S_SHOW;
                S_SHOW:    state_d = S_LOAD_B;
                default:   state_d = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // load_d resets high so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            load_d  <= 1'b1;
            reg_a   <= '0;
            reg_b   <= '0;
            op_q    <= '0;
            leds_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            load_d <= bus.i_load;
            if (load_ev) begin
                case (state_q)
                    S_LOAD_A: reg_a <= bus.i_dato;
                    S_LOAD_B: reg_b <= bus.i_dato;
                    S_LOAD_OP: begin
                        op_q    <= bus.i_operation;
                        leds_q  <= alu_res;
                        carry_q <= alu_cy;
                        zero_q  <= (alu_res == '0);
                        err_q   <= alu_err;
                        valid_q <= 1'b1;
                    end
                    S_SHOW: begin
                        reg_a   <= bus.i_dato;
                        valid_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_leds   = leds_q;
    assign bus.o_state  = state_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_carry  = carry_q;
    assign bus.o_zero   = zero_q;
    assign bus.o_op_err = err_q;

endmodule

// File: tb/tb_alu_seq_loader.sv
// Randomized and directed bench for alu_seq_loader against a behavioural model of the loader.
module tb_alu_seq_loader;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_seq_loader_if #(.NB_DATA(NB), .NB_OP(6)) ifc ();

    alu_seq_loader #(.NB_DATA(NB), .NB_OP(6)) dut (
        .clk     (clk),
        .i_reset (rst),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    // Model: which operand the next press captures (0=A,1=B,2=op,3=showing).
    int m_phase, m_a, m_b, m_leds, m_cy, m_zero, m_err, m_valid, m_prev;

    int op_list [8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h03, 'h02};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input int aa, input int bb, input int op,
                                    output int res, output int cy, output int er);
        int sa;
        res = 0; cy = 0; er = 0;
        sa = (aa >= 128) ? aa - 256 : aa;
        case (op)
            'h20: begin res = (aa + bb) % 256; cy = (aa + bb) / 256; end
            'h22: begin res = (aa - bb + 256) % 256; cy = (aa < bb) ? 1 : 0; end
            'h24: res = aa & bb;
            'h25: res = aa | bb;
            'h26: res = aa ^ bb;
            'h27: res = (~(aa | bb)) & 255;
            'h03: res = (bb >= NB) ? ((aa >= 128) ? 255 : 0) : ((sa >>> bb) & 255);
            'h02: res = (bb >= NB) ? 0 : (aa >> bb);
            default: er = 1;
        endcase
    endfunction

    task automatic model_edge(input int ld, input int d, input int op, input int r);
        int res, cy, er;
        if (r != 0) begin
            m_phase = 0; m_a = 0; m_b = 0; m_leds = 0;
            m_cy = 0; m_zero = 0; m_err = 0; m_valid = 0; m_prev = 1;
        end else begin
            if (ld != 0 && m_prev == 0) begin
                if (m_phase == 0) begin
                    m_a = d; m_phase = 1;
                end else if (m_phase == 1) begin
                    m_b = d; m_phase = 2;
                end else if (m_phase == 2) begin
                    ref_alu(m_a, m_b, op, res, cy, er);
                    m_leds = res; m_cy = cy; m_err = er;
                    m_zero = (res == 0) ? 1 : 0;
                    m_valid = 1; m_phase = 3;
                end else begin
                    m_a = d; m_valid = 0; m_phase = 1;
                end
            end
            m_prev = ld;
        end
    endtask

    // Drive inputs, advance one edge, then compare every output with the model.
    task automatic step(input int ld, input int d, input int op, input int r);
        ifc.i_load      = (ld != 0);
        ifc.i_dato      = d[NB-1:0];
        ifc.i_operation = op[5:0];
        rst             = (r != 0);
        @(posedge clk);
        model_edge(ld, d, op, r);
        #1;
        check("leds",  32'(ifc.o_leds),   32'(m_leds));
        check("state", 32'(ifc.o_state),  32'(m_phase));
        check("valid", 32'(ifc.o_valid),  32'(m_valid));
        check("carry", 32'(ifc.o_carry),  32'(m_cy));
        check("zero",  32'(ifc.o_zero),   32'(m_zero));
        check("op_err", 32'(ifc.o_op_err), 32'(m_err));
    endtask

    task automatic press(input int d, input int op);
        step(1, d, op, 0);
        step(0, d, op, 0);
    endtask

    task automatic run_op(input int a, input int b, input int op);
        press(a, 0);
        press(b, 0);
        press(0, op);
    endtask

    initial begin
        int ld, d, op, r;
        m_prev = 1; m_phase = 0;
        ifc.i_load = 1'b0; ifc.i_dato = '0; ifc.i_operation = '0;

        // Two reset cycles
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_leds", 32'(ifc.o_leds), 32'h00);
        check("rst_state", 32'(ifc.o_state), 32'h0);
        step(0, 0, 0, 0);

        run_op('h05, 'h03, 'h20);
        check("add_leds", 32'(ifc.o_leds), 32'h08);
        check("add_state", 32'(ifc.o_state), 32'h3);
        check("add_valid", 32'(ifc.o_valid), 32'h1);
        // From SHOW, next press is a fresh A
        press('h05, 0);
        check("show_state", 32'(ifc.o_state), 32'h1);
        check("show_valid", 32'(ifc.o_valid), 32'h0);
        check("show_leds_hold", 32'(ifc.o_leds), 32'h08);
        press('h07, 0);
        press(0, 'h22);
        check("sub_leds", 32'(ifc.o_leds), 32'hFE);
        check("sub_carry", 32'(ifc.o_carry), 32'h1);

        press('hFF, 0); press('h01, 0); press(0, 'h20);
        check("addwrap_leds", 32'(ifc.o_leds), 32'h00);
        check("addwrap_carry", 32'(ifc.o_carry), 32'h1);
        check("addwrap_zero", 32'(ifc.o_zero), 32'h1);

        press('h80, 0); press('h02, 0); press(0, 'h03);
        check("sra2", 32'(ifc.o_leds), 32'hE0);
        press('h80, 0); press('h02, 0); press(0, 'h02);
        check("srl2", 32'(ifc.o_leds), 32'h20);
        press('h80, 0); press('h09, 0); press(0, 'h03);
        check("sra9", 32'(ifc.o_leds), 32'hFF);
        press('h80, 0); press('h09, 0); press(0, 'h02);
        check("srl9", 32'(ifc.o_leds), 32'h00);

        // Long press from S_LOAD_A gives exactly one capture
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 'h11 + i, 0, 0);
        check("hold_state", 32'(ifc.o_state), 32'h1);
        step(0, 0, 0, 0);

        // Button held through reset release
        step(1, 'h22, 0, 1);
        step(1, 'h22, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 'h22, 0, 0);
        check("held_rst_state", 32'(ifc.o_state), 32'h0);
        step(0, 'h22, 0, 0);
        step(1, 'h22, 0, 0);
        check("rearm_state", 32'(ifc.o_state), 32'h1);
        step(0, 'h22, 0, 0);

        // Reset while waiting for the opcode, then an unsupported opcode
        press('h33, 0);
        check("pre_abort_state", 32'(ifc.o_state), 32'h2);
        step(0, 0, 0, 1);
        check("abort_state", 32'(ifc.o_state), 32'h0);
        check("abort_valid", 32'(ifc.o_valid), 32'h0);
        step(0, 0, 0, 0);
        run_op('h03, 'h04, 'h3F);
        check("bad_leds", 32'(ifc.o_leds), 32'h00);
        check("bad_err", 32'(ifc.o_op_err), 32'h1);
        check("bad_zero", 32'(ifc.o_zero), 32'h1);
        check("bad_valid", 32'(ifc.o_valid), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom_range(0, 9) < 4) ? 1 : 0;
            d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 255);
            op = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 63) : op_list[$urandom_range(0, 7)];
            r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
            step(ld, d, op, r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_loader.md
ALU_SEQ_LOADER -- requirements
Module: alu_seq_loader

Interface
REQ-001 Parameter NB_DATA, default 8, operand and result width (legal range 4..32).
REQ-002 Parameter NB_OP, default 6, opcode width; the opcode values are fixed 6-bit codes, so NB_OP SHALL be 6.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_dato  input  NB_DATA  operand value from the switches.
REQ-006 i_operation  input  NB_OP  opcode from the switches.
REQ-007 i_load  input  1  level load button, already debounced and synchronised outside this block.
REQ-008 o_leds  output  NB_DATA  registered result.
REQ-009 o_state  output  2  current FSM state encoding.
REQ-010 o_valid  output  1  o_leds holds the result of the current operand set.
REQ-011 o_carry  output  1  ADD carry-out, or SUB borrow.
REQ-012 o_zero  output  1  registered result equals 0.
REQ-013 o_op_err  output  1  last captured opcode was unsupported.

Function
REQ-014 Load event: i_load sampled 1 at an edge while its previous sample (register load_d) is 0; exactly one event per press, regardless of how long i_load is held.
REQ-015 FSM states: S_LOAD_A=2'b00, S_LOAD_B=2'b01, S_LOAD_OP=2'b10, S_SHOW=2'b11; o_state SHALL equal the state register.
REQ-016 S_LOAD_A + event: capture i_dato into reg_a, go to S_LOAD_B.
REQ-017 S_LOAD_B + event: capture i_dato into reg_b, go to S_LOAD_OP.
REQ-018 S_LOAD_OP + event: capture i_operation, compute from reg_a and reg_b, register o_leds, o_carry, o_zero, o_op_err, set o_valid=1, go to S_SHOW; all updates on that same edge.
REQ-019 S_SHOW + event: capture i_dato into reg_a, clear o_valid, go to S_LOAD_B; o_leds and the flags hold their last values.
REQ-020 With no event, the state and all registers hold.
REQ-021 Opcodes (result is NB_DATA bits, with wrap-around):
- ADD 6'b100000: A+B; carry = bit NB_DATA of the sum.
- SUB 6'b100010: A-B; carry = 1 iff A<B (unsigned).
- AND 6'b100100 / OR 6'b100101 / XOR 6'b100110 / NOR 6'b100111: bitwise; carry 0.
- SRA 6'b000011: A arithmetic-shifted right by B (unsigned); for B>=NB_DATA, all bits equal A's MSB; carry 0.
- SRL 6'b000010: A logical-shifted right by B; for B>=NB_DATA, result 0; carry 0.
REQ-022 Any other opcode: result 0, carry 0, zero 1, o_op_err 1, o_valid still 1; o_op_err SHALL be 0 for supported opcodes.
REQ-023 o_zero SHALL be 1 exactly when the registered result is 0.
REQ-024 o_leds and the flags SHALL change only on a REQ-018 capture or on reset.

Reset
REQ-025 i_reset SHALL take priority over any load event on the same edge.
REQ-026 On reset: state=S_LOAD_A; reg_a, reg_b, the opcode register, o_leds, o_carry, o_zero, o_op_err and o_valid = 0.
REQ-027 On reset: load_d=1, so an i_load held high through reset produces no event until it has been released.
REQ-028 Reset asserted in any state SHALL abort the sequence, and the next event SHALL capture A.

Verification (NB_DATA=8)
REQ-029 Assert i_reset for 2 cycles -> o_leds=0x00, o_valid=0, o_state=00, all flags 0.
REQ-030 Load A=0x05, B=0x03, op=100000 -> o_leds=0x08, carry=0, zero=0, valid=1, state=11; then load A=0x05, B=0x07, op=100010 -> o_leds=0xFE, carry=1, zero=0, valid=1.
REQ-031 Load A=0xFF, B=0x01, op=ADD -> o_leds=0x00, carry=1, zero=1.
REQ-032 A=0x80, B=0x02: SRA -> 0xE0, SRL -> 0x20; A=0x80, B=0x09: SRA -> 0xFF, SRL -> 0x00.
REQ-033 Hold i_load high for 10 cycles from S_LOAD_A -> exactly one capture, state=01; hold i_load through reset release -> state stays 00 until i_load falls and rises again.
REQ-034 Reset in S_LOAD_OP -> state=00, valid=0; then an op load of 6'b111111 after a full A/B load -> o_leds=0x00, o_op_err=1, o_zero=1, o_valid=1.
